// File: rtl/rco_event_capture_pkg.sv
// Shared constants for the rco/load event monitor.
// Build option: RCO_EVT_TS_EN prepends a free-running timestamp to each record.
package rco_event_capture_pkg;

    localparam logic [1:0] EVT_NONE = 2'b00;
    localparam logic [1:0] EVT_RCO  = 2'b01;
    localparam logic [1:0] EVT_LOAD = 2'b10;
    localparam logic [1:0] EVT_BOTH = 2'b11;

`ifdef RCO_EVT_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Record width: {ts (optional), type[1:0], hi, q[3:0]}
    function automatic int evt_data_w(input int hi_w, input int ts_w, input bit ts_en);
        return (ts_en ? ts_w : 0) + 2 + hi_w + 4;
    endfunction

endpackage

// File: rtl/rco_event_capture_evt_fifo.sv
// Small synchronous FIFO for event records. A push into a full FIFO is
// accepted when a pop happens on the same edge. While empty, dout keeps
// showing the last record that was popped (zero after reset).
module evt_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] last_q;
    logic              do_pop;
    logic              do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? last_q : mem[rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Remember the record leaving the head so the output holds it when empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= '0;
        end else if (do_pop) begin
            last_q <= mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: rtl/rco_event_capture.sv
// Monitor for the 4-bit counter: turns rco/load rising edges into tagged
// records {type, hi, q}, extends the count via an rco-driven high counter,
// and queues records toward the consumer. Drops on a full queue are counted.
// Build option: RCO_EVT_TS_EN adds a free-running timestamp as record MSBs.
module rco_event_capture
    import rco_event_capture_pkg::*;
#(
    parameter int HI_W   = 8,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 16,
    localparam int DATA_W = evt_data_w(HI_W, TS_W, TS_EN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mon_en,
    input  logic              load,
    input  logic              rco,
    input  logic [3:0]        Q,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [DATA_W-1:0] ev_data,
    output logic [HI_W-1:0]   hi_count,
    output logic              ovf,
    output logic [7:0]        drop_cnt,
    input  logic              clr_ovf
);

    logic              load_q;
    logic              rco_q;
    logic              load_ev;
    logic              rco_ev;
    logic [1:0]        evt_type;
    logic              evt_push;
    logic              evt_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;
    logic [DATA_W-1:0] rec;

    assign load_ev  = mon_en & load & ~load_q;
    assign rco_ev   = mon_en & rco & ~rco_q;
    assign evt_push = (evt_type != EVT_NONE);
    assign ev_valid = ~fifo_empty;
    assign evt_pop  = ev_valid & ev_ready;
    assign drop     = evt_push & fifo_full & ~evt_pop;

    // Classify the qualified edges of this cycle.
    always_comb begin
        evt_type = EVT_NONE;
        case ({load_ev, rco_ev})
            2'b01:   evt_type = EVT_RCO;
            2'b10:   evt_type = EVT_LOAD;
            2'b11:   evt_type = EVT_BOTH;
            default: evt_type = EVT_NONE;
        endcase
    end

    // Edge-detect history follows the inputs even while disabled, so
    // re-enabling with rco/load already high does not create an event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_q <= 1'b0;
            rco_q  <= 1'b0;
        end else begin
            load_q <= load;
            rco_q  <= rco;
        end
    end

    // High count: load clears (wins over rco), rco increments with natural wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_count <= '0;
        end else if (load_ev) begin
            hi_count <= '0;
        end else if (rco_ev) begin
            hi_count <= hi_count + HI_W'(1);
        end
    end

    // Overflow tracking; a drop on the same edge as a clear leaves one drop recorded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf      <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= 8'd0;
        end
    end

`ifdef RCO_EVT_TS_EN
    logic [TS_W-1:0] ts_cnt;

    // Free-running timestamp, wraps silently.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    assign rec = {ts_cnt, evt_type, hi_count, Q};
`else
    assign rec = {evt_type, hi_count, Q};
`endif

    evt_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (evt_push),
        .pop   (evt_pop),
        .din   (rec),
        .dout  (ev_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
